// File: rtl/snn_soc_pkg.sv
// Shared SNN SoC constants and types used by the ADC scan / differential stage.
package snn_soc_pkg;

    localparam int unsigned NUM_OUTPUTS        = 10;
    localparam int unsigned ADC_CHANNELS       = 20;
    localparam int unsigned ADC_BITS           = 8;
    localparam int unsigned ADC_TIMEOUT_CYCLES = 255;

    typedef logic signed [ADC_BITS:0] adc_diff_t;

endpackage

// File: rtl/adc_scan_diff_ctrl_if.sv
// ADC macro handshake plus differential result bus of the scan controller.
interface adc_scan_diff_ctrl_if
    import snn_soc_pkg::*;
#(
    parameter int unsigned P_NUM_OUTPUTS  = NUM_OUTPUTS,
    parameter int unsigned P_ADC_CHANNELS = ADC_CHANNELS,
    parameter int unsigned P_ADC_BITS     = ADC_BITS
) ();

    localparam int unsigned SEL_W = $clog2(P_ADC_CHANNELS);

    logic                                  adc_start;
    logic                                  adc_done;
    logic [SEL_W-1:0]                      bl_sel;
    logic [P_ADC_BITS-1:0]                 bl_data;
    logic                                  diff_valid;
    logic [P_NUM_OUTPUTS-1:0][P_ADC_BITS:0] diff_data;

    // master: scan controller; slave: macro / neuron stage side
    modport master (
        output adc_start, bl_sel, diff_valid, diff_data,
        input  adc_done, bl_data
    );

    modport slave (
        input  adc_start, bl_sel, diff_valid, diff_data,
        output adc_done, bl_data
    );

endinterface

// File: rtl/adc_scan_diff_ctrl.sv
// Scans every BL column through the macro ADC, then forms signed pos-neg
// differentials per neuron with a per-channel conversion watchdog.
module adc_scan_diff_ctrl
    import snn_soc_pkg::*;
#(
    parameter int unsigned P_NUM_OUTPUTS    = NUM_OUTPUTS,
    parameter int unsigned P_ADC_CHANNELS   = ADC_CHANNELS,
    parameter int unsigned P_ADC_BITS       = ADC_BITS,
    parameter int unsigned P_TIMEOUT_CYCLES = ADC_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_start,
    output logic                 busy,
    output logic                 timeout_err,
    adc_scan_diff_ctrl_if.master bus
);

    localparam int unsigned SEL_W = $clog2(P_ADC_CHANNELS);
    localparam int unsigned TMO_W = $clog2(P_TIMEOUT_CYCLES + 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(P_ADC_CHANNELS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT_CYCLES - 1);

    typedef logic [P_ADC_BITS-1:0] code_t;
    typedef logic [P_NUM_OUTPUTS-1:0][P_ADC_BITS:0] diff_vec_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DIFF  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             adc_start_q, adc_start_d;
    logic [SEL_W-1:0] bl_sel_q, bl_sel_d;
    logic             diff_valid_q, diff_valid_d;
    diff_vec_t        diff_q, diff_d;

    code_t            raw_q [P_ADC_CHANNELS];
    code_t            raw_view_c [P_ADC_CHANNELS];
    diff_vec_t        diff_calc_c;
    logic             raw_wr_c;

    assign raw_wr_c = (state_q == S_WAIT) && bus.adc_done;

    // Raw buffer as it will look after this cycle's capture, so the final
    // differential can be registered together with the diff_valid pulse.
    always_comb begin
        for (int unsigned k = 0; k < P_ADC_CHANNELS; k++) begin
            raw_view_c[k] = raw_q[k];
            if (raw_wr_c && (sel_q == SEL_W'(k))) begin
                raw_view_c[k] = bus.bl_data;
            end
        end
    end

    always_comb begin
        diff_calc_c = '0;
        for (int unsigned i = 0; i < P_NUM_OUTPUTS; i++) begin
            diff_calc_c[i] = (P_ADC_BITS + 1)'($signed({1'b0, raw_view_c[i]})
                                            - $signed({1'b0, raw_view_c[i + P_NUM_OUTPUTS]}));
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        diff_d  = diff_q;

        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    state_d = S_START;
                    sel_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (bus.adc_done) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = S_DIFF;
                        diff_d  = diff_calc_c;
                    end else begin
                        state_d = S_START;
                        sel_d   = sel_q + SEL_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DIFF: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it
        busy_d       = (state_d != S_IDLE);
        adc_start_d  = (state_d == S_START);
        diff_valid_d = (state_d == S_DIFF);
        bl_sel_d     = (state_d == S_IDLE) ? '0 : sel_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            adc_start_q  <= 1'b0;
            bl_sel_q     <= '0;
            diff_valid_q <= 1'b0;
            diff_q       <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            adc_start_q  <= adc_start_d;
            bl_sel_q     <= bl_sel_d;
            diff_valid_q <= diff_valid_d;
            diff_q       <= diff_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < P_ADC_CHANNELS; k++) begin
                raw_q[k] <= '0;
            end
        end else if (raw_wr_c) begin
            raw_q[sel_q] <= bus.bl_data;
        end
    end

    assign busy           = busy_q;
    assign timeout_err    = err_q;
    assign bus.adc_start  = adc_start_q;
    assign bus.bl_sel     = bl_sel_q;
    assign bus.diff_valid = diff_valid_q;
    assign bus.diff_data  = diff_q;

    generate
        if (P_ADC_CHANNELS != 2 * P_NUM_OUTPUTS) begin : g_bad_channels
            $error("adc_scan_diff_ctrl: P_ADC_CHANNELS must equal 2*P_NUM_OUTPUTS");
        end
        if ((P_TIMEOUT_CYCLES < 1) || (P_TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
            $error("adc_scan_diff_ctrl: P_TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    a_sel_range: assert property (@(posedge clk) disable iff (rst)
        {1'b0, bus.bl_sel} < (SEL_W + 1)'(P_ADC_CHANNELS));

    a_start_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.adc_start |=> !bus.adc_start);

endmodule

// File: doc/adc_scan_diff_ctrl.md
Name: adc_scan_diff_ctrl

Overview:
- Sits directly downstream of the CIM macro's ADC interface.
- After each CIM compute, sequences single-channel ADC conversions across all BL columns: drives adc_start and bl_sel, waits for adc_done, and captures bl_data.
- Forms the signed Scheme-B differential diff[i] = pos[i] - neg[i] for every output neuron and presents it to the neuron/membrane stage with a one-cycle valid pulse.
- Includes a conversion-timeout watchdog.

Parameters:
- P_NUM_OUTPUTS, snn_soc_pkg::NUM_OUTPUTS (10), number of differential pairs (neurons).
- P_ADC_CHANNELS, snn_soc_pkg::ADC_CHANNELS (20), BL columns scanned; must equal 2*P_NUM_OUTPUTS.
- P_ADC_BITS, snn_soc_pkg::ADC_BITS (8), raw ADC width.
- P_TIMEOUT_CYCLES, 255, maximum WAIT cycles per channel before abort; range 1..255.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- scan_start  in  1  one-cycle pulse requesting a full 20-channel scan.
- busy  out  1  high from acceptance of scan_start until return to IDLE.
- adc_start  out  1  one-cycle conversion trigger to the macro.
- adc_done  in  1  one-cycle conversion-complete pulse from the macro.
- bl_sel  out  $clog2(P_ADC_CHANNELS)  channel select to the macro's bl_data mux.
- bl_data  in  P_ADC_BITS  unsigned ADC code for the current bl_sel.
- diff_valid  out  1  one-cycle pulse: diff_data updated.
- diff_data  out  P_NUM_OUTPUTS x (P_ADC_BITS+1)  signed two's-complement differentials, packed with element 0 at the LSBs.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy, adc_start, diff_valid, timeout_err = 0; bl_sel=0; diff_data=0; raw buffer cleared; sel and timeout counters = 0. Reset mid-scan aborts immediately with no diff_valid.
- FSM states: IDLE, START, WAIT, DIFF.
- IDLE:
  - bl_sel=0.
  - scan_start=1 → START, sel=0, busy=1 from the next cycle.
  - Clears timeout_err on acceptance.
- START:
  - adc_start=1 for exactly this cycle; bl_sel=sel.
  - Next state is WAIT; timeout counter = 0.
- WAIT:
  - bl_sel held at sel (stable, because the macro mux is combinational).
  - adc_done=1 → raw[sel] <= bl_data in that same cycle.
    - If sel == P_ADC_CHANNELS-1 → DIFF.
    - Otherwise sel++ → START.
  - No adc_done → counter++.
  - Counter reaches P_TIMEOUT_CYCLES-1 without adc_done → timeout_err=1, next state IDLE, no diff_valid, diff_data unchanged.
- DIFF:
  - diff_data[i] <= $signed({1'b0, raw[i]}) - $signed({1'b0, raw[i+P_NUM_OUTPUTS]}) for i=0..P_NUM_OUTPUTS-1.
  - Width is P_ADC_BITS+1, range -255..+255, so overflow is impossible.
  - diff_valid=1 for this cycle only; next state IDLE.
- busy: 1 in START, WAIT and DIFF.
- Conflict and spurious-input rules:
  - scan_start while busy is ignored (no queueing).
  - adc_done in IDLE, START or DIFF is ignored and does not write raw.
  - scan_start in the same cycle as rst: reset wins.
- Latency: per channel = 1 START cycle + the macro's adc_done delay. Total scan = 20*(1+L) + 1 (DIFF) cycles after acceptance, where L is the START→adc_done distance. diff_valid asserts the cycle after the last adc_done.
- diff_data holds its value until the next successful scan or reset.
- Simulation-only assertions:
  - bl_sel < P_ADC_CHANNELS.
  - adc_start never 1 for two consecutive cycles.
  - P_ADC_CHANNELS == 2*P_NUM_OUTPUTS (elaboration check).

Decomposition:
- snn_soc_pkg:
  - reuses NUM_OUTPUTS, ADC_CHANNELS, ADC_BITS;
  - adds ADC_TIMEOUT_CYCLES (255) and typedef logic signed [ADC_BITS:0] adc_diff_t.
- The FSM state enum stays local to the module.
- No sub-module: the subtract array is a single registered loop. A separate diff unit is not warranted.

Test Plan:
- Macro model, wl popcount=10, L=3; pulse scan_start → 20 adc_start pulses with bl_sel 0..19 in order; diff_valid once, 81 cycles after acceptance; all diff_data = 15 (pos 20+j, neg 5+j).
- Popcount=64 → all diff=+96. Popcount=0 → all diff=0; busy falls the cycle after diff_valid.
- Bench-driven bl_data: pos=0, neg=255 on pair 3, others pos=200/neg=100 → diff[3] = -255 (9'h101), others +100.
- adc_done withheld on channel 7 → timeout_err=1 after 255 WAIT cycles; state IDLE, no diff_valid, diff_data keeps the previous scan. Next scan_start clears timeout_err and the scan completes normally.
- scan_start re-pulsed during WAIT of channel 4 and a spurious adc_done in IDLE → both ignored: exactly 20 adc_start pulses, results unchanged.
- rst asserted during channel 12 WAIT → next cycle all outputs at reset values, no diff_valid. A fresh scan then produces correct results.
